// File: rtl/adder_pkg.sv
// Shared helpers for the chunked pipelined adder: parameter legality and chunk sizing.
package adder_pkg;

  localparam int MAX_CHUNK = 64;

  typedef logic [MAX_CHUNK-1:0] chunk_t;

  function automatic bit check_params(input int width, input int stages);
    return (stages >= 1) && (width >= 1) && ((width % stages) == 0);
  endfunction

  function automatic int chunk_width(input int width, input int stages);
    return (stages >= 1) ? (width / stages) : width;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple-carry adder used as one slice of the pipelined adder.
module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] sum,
  output logic             c_out
);

  logic [CHUNK:0] carry;

  always_comb begin
    sum      = '0;
    carry    = '0;
    carry[0] = c_in;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    c_out = carry[CHUNK];
  end

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder split into STAGES registered chunks with valid/ready and global stall.
// Define PIPE_ADD_OVF_EN to add the signed overflow output.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef PIPE_ADD_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  if (!check_params(WIDTH, STAGES)) begin : g_bad_params
    $error("pipelined_adder: STAGES must be >= 1 and divide WIDTH");
  end

  logic                              adv;
  logic [STAGES-1:0]                 vld_st, cin_st, chunk_cout;
  logic [STAGES-1:0]                 vld_d, vld_q, carry_d, carry_q;
  logic [STAGES-1:0][WIDTH-1:0]      a_st, b_st, sum_st;
  logic [STAGES-1:0][WIDTH-1:0]      a_d, a_q, b_d, b_q, sum_d, sum_q;
  logic [STAGES-1:0][CHUNK-1:0]      chunk_sum;
  logic                              skew_unused;

  // Stage k sees either the primary inputs or the registers of stage k-1.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign a_st[k]   = a;
      assign b_st[k]   = b;
      assign cin_st[k] = c_in;
      assign vld_st[k] = in_valid;
      assign sum_st[k] = '0;
    end else begin : g_tail
      assign a_st[k]   = a_q[k-1];
      assign b_st[k]   = b_q[k-1];
      assign cin_st[k] = carry_q[k-1];
      assign vld_st[k] = vld_q[k-1];
      assign sum_st[k] = sum_q[k-1];
    end

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a     (a_st[k][k*CHUNK +: CHUNK]),
      .b     (b_st[k][k*CHUNK +: CHUNK]),
      .c_in  (cin_st[k]),
      .sum   (chunk_sum[k]),
      .c_out (chunk_cout[k])
    );
  end

  // The last stage's operand copy is never consumed; only the sum leaves.
  assign skew_unused = ^{a_q[STAGES-1], b_q[STAGES-1]};

  assign adv       = !vld_q[STAGES-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign c_out     = carry_q[STAGES-1];

  always_comb begin
    vld_d   = vld_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    if (adv) begin
      vld_d   = vld_st;
      carry_d = chunk_cout;
      a_d     = a_st;
      b_d     = b_st;
      for (int k = 0; k < STAGES; k++) begin
        sum_d[k]                   = sum_st[k];
        sum_d[k][k*CHUNK +: CHUNK] = chunk_sum[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      carry_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      vld_q   <= vld_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

`ifdef PIPE_ADD_OVF_EN
  logic ovf_d, ovf_q;

  // Sign bits reach the last stage through the skew registers.
  always_comb begin
    ovf_d = ovf_q;
    if (adv) begin
      ovf_d = (a_st[STAGES-1][WIDTH-1] == b_st[STAGES-1][WIDTH-1]) &&
              (chunk_sum[STAGES-1][CHUNK-1] != a_st[STAGES-1][WIDTH-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder (8-bit/2-stage and 1-bit/1-stage instances).
module tb_pipelined_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  int         tests = 0;
  int         fails = 0;

  logic       in_valid8, in_ready8, c_in8, out_valid8, out_ready8, c_out8;
  logic [7:0] a8, b8, sum8;
  logic       in_valid1, in_ready1, c_in1, out_valid1, out_ready1, c_out1;
  logic [0:0] a1, b1, sum1;
`ifdef PIPE_ADD_OVF_EN
  logic       ovf8, ovf1;
`endif

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(8), .STAGES(2)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .c_in      (c_in8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .sum       (sum8),
    .c_out     (c_out8)
`ifdef PIPE_ADD_OVF_EN
    ,
    .overflow  (ovf8)
`endif
  );

  pipelined_adder #(.WIDTH(1), .STAGES(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .c_in      (c_in1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .sum       (sum1),
    .c_out     (c_out1)
`ifdef PIPE_ADD_OVF_EN
    ,
    .overflow  (ovf1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic v, input logic [7:0] av, input logic [7:0] bv, input logic cv);
    in_valid8 = v;
    a8        = av;
    b8        = bv;
    c_in8     = cv;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    out_ready8 = 1'b1;
    out_ready1 = 1'b1;
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    in_valid1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c_in1 = 1'b0;
    #12;
    check("rst_out_valid", {31'b0, out_valid8}, 32'd0);
    check("rst_sum",       {24'b0, sum8},       32'd0);
    check("rst_c_out",     {31'b0, c_out8},     32'd0);
    check("rst_in_ready",  {31'b0, in_ready8},  32'd1);
    check("rst_out_valid1",{31'b0, out_valid1}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 0x0F + 0x01: two-cycle latency
    drive8(1'b1, 8'h0F, 8'h01, 1'b0);
    tick();
    check("t1_lat1_valid", {31'b0, out_valid8}, 32'd0);
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    check("t1_valid", {31'b0, out_valid8}, 32'd1);
    check("t1_sum",   {24'b0, sum8},       32'h10);
    check("t1_c_out", {31'b0, c_out8},     32'd0);

    // 0xFF + 0x01: carry crosses the chunk boundary
    drive8(1'b1, 8'hFF, 8'h01, 1'b0);
    tick();
    check("t2_gap_valid", {31'b0, out_valid8}, 32'd0);
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    check("t2_valid", {31'b0, out_valid8}, 32'd1);
    check("t2_sum",   {24'b0, sum8},       32'h00);
    check("t2_c_out", {31'b0, c_out8},     32'd1);

    // back-to-back stream a=i, b=0x10, c_in=1
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc < 8) drive8(1'b1, 8'(cyc), 8'h10, 1'b1);
      else         drive8(1'b0, 8'h00, 8'h00, 1'b0);
      tick();
      if (cyc >= 1 && cyc <= 8) begin
        check("t3_valid", {31'b0, out_valid8}, 32'd1);
        check("t3_sum",   {24'b0, sum8},       32'(cyc - 1 + 8'h11));
        check("t3_c_out", {31'b0, c_out8},     32'd0);
      end else begin
        check("t3_idle_valid", {31'b0, out_valid8}, 32'd0);
      end
    end

    // backpressure: fill the pipe with out_ready low
    out_ready8 = 1'b0;
    drive8(1'b1, 8'h20, 8'h01, 1'b0);
    tick();
    check("t4_fill_valid", {31'b0, out_valid8}, 32'd0);
    drive8(1'b1, 8'h30, 8'h02, 1'b0);
    tick();
    check("t4_full_valid",    {31'b0, out_valid8}, 32'd1);
    check("t4_full_sum",      {24'b0, sum8},       32'h21);
    check("t4_full_in_ready", {31'b0, in_ready8},  32'd0);
    drive8(1'b1, 8'h40, 8'h03, 1'b0);
    for (int s = 0; s < 3; s++) begin
      tick();
      check("t4_stall_valid",    {31'b0, out_valid8}, 32'd1);
      check("t4_stall_sum",      {24'b0, sum8},       32'h21);
      check("t4_stall_c_out",    {31'b0, c_out8},     32'd0);
      check("t4_stall_in_ready", {31'b0, in_ready8},  32'd0);
    end
    out_ready8 = 1'b1;
    #1;
    check("t4_release_in_ready", {31'b0, in_ready8}, 32'd1);
    tick();
    check("t4_drain1_valid", {31'b0, out_valid8}, 32'd1);
    check("t4_drain1_sum",   {24'b0, sum8},       32'h32);
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    check("t4_drain2_valid", {31'b0, out_valid8}, 32'd1);
    check("t4_drain2_sum",   {24'b0, sum8},       32'h43);
    tick();
    check("t4_empty_valid",  {31'b0, out_valid8}, 32'd0);

    // asynchronous reset with results in flight
    drive8(1'b1, 8'h55, 8'h11, 1'b0);
    tick();
    drive8(1'b1, 8'h70, 8'h01, 1'b0);
    tick();
    check("t5_pre_valid", {31'b0, out_valid8}, 32'd1);
    check("t5_pre_sum",   {24'b0, sum8},       32'h66);
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", {31'b0, out_valid8}, 32'd0);
    check("t5_rst_sum",   {24'b0, sum8},       32'd0);
    check("t5_rst_c_out", {31'b0, c_out8},     32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      check("t5_post_valid", {31'b0, out_valid8}, 32'd0);
    end

    // 1-bit single-stage instance: full-adder truth table
    for (int v = 0; v < 8; v++) begin
      logic [2:0] vv;
      logic [1:0] fa;
      vv        = v[2:0];
      fa        = 2'(vv[2]) + 2'(vv[1]) + 2'(vv[0]);
      in_valid1 = 1'b1;
      a1        = vv[2];
      b1        = vv[1];
      c_in1     = vv[0];
      tick();
      check("t6_fa_valid", {31'b0, out_valid1}, 32'd1);
      check("t6_fa_sum",   {31'b0, sum1},       {31'b0, fa[0]});
      check("t6_fa_c_out", {31'b0, c_out1},     {31'b0, fa[1]});
    end
    in_valid1 = 1'b0;
    tick();
    check("t6_fa_idle_valid", {31'b0, out_valid1}, 32'd0);

`ifdef PIPE_ADD_OVF_EN
    drive8(1'b1, 8'h7F, 8'h01, 1'b0);
    tick();
    drive8(1'b1, 8'hFF, 8'h01, 1'b0);
    tick();
    check("t7_ovf_valid", {31'b0, out_valid8}, 32'd1);
    check("t7_ovf_sum",   {24'b0, sum8},       32'h80);
    check("t7_ovf_set",   {31'b0, ovf8},       32'd1);
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    check("t7_novf_sum",   {24'b0, sum8},   32'h00);
    check("t7_novf_c_out", {31'b0, c_out8}, 32'd1);
    check("t7_novf_clear", {31'b0, ovf8},   32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
